// File: rtl/v_store_engine.sv
// v_store_engine: vector store engine issuing one element per bank per beat
module v_store_engine #(
  parameter int VLEN   = 128,
  parameter int NBANKS = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       strided,
  input  logic [2:0]                 vsew,
  input  logic [2:0]                 lmul,
  input  logic [ADDR_W-1:0]          stride,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [4*VLEN-1:0]          data,
  input  logic                       vm,
  input  logic [4*VLEN/8-1:0]        mask,
  input  logic                       mem_ready,
  output logic [NBANKS*ADDR_W-1:0]   bank_addr,
  output logic [NBANKS*DATA_W-1:0]   bank_wdata,
  output logic [NBANKS-1:0]          bank_we,
  output logic                       busy,
  output logic                       done
);
  localparam int MAXELEM = 4*VLEN/8;
  localparam int BW = $clog2(MAXELEM) + 1;
  localparam int EW = BW + 4;
  localparam int NL = $clog2(NBANKS);
  typedef enum logic [1:0] {IDLE = 2'd0, STORE = 2'd1, DONE = 2'd2} state_t;
  state_t               r_state, w_next;
  logic                 r_strided, r_vm;
  logic [1:0]           r_sew, r_lmul;
  logic [ADDR_W-1:0]    r_stride, r_base;
  logic [4*VLEN-1:0]    r_data;
  logic [MAXELEM-1:0]   r_mask;
  logic [BW-1:0]        r_beat;
  logic [EW-1:0]        w_nelem, w_nbeat;
  logic                 w_last, w_st;
  // sew and lmul are kept as log2 values so element counts reduce to shifts
  assign w_nelem = EW'(VLEN >> ({1'b0, r_sew} + 3'd3)) << r_lmul;
  assign w_nbeat = (w_nelem + EW'(NBANKS - 1)) >> NL;
  assign w_last  = EW'(r_beat) == w_nbeat - EW'(1);
  assign w_st    = r_state == STORE;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next-state: start only seen in IDLE, leave STORE once the last beat is accepted
  always_comb begin
    w_next = r_state == IDLE  ? (start ? STORE : IDLE) :
             r_state == STORE ? ((mem_ready && w_last) ? DONE : STORE) : IDLE;
  end
  // status outputs
  always_comb begin
    busy = r_state == STORE || r_state == DONE;
    done = r_state == DONE;
  end
  // capture the request once, later input changes are ignored until IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strided <= 1'b0;
      r_vm      <= 1'b0;
      r_sew     <= 2'd0;
      r_lmul    <= 2'd0;
      r_stride  <= '0;
      r_base    <= '0;
      r_data    <= '0;
      r_mask    <= '0;
    end else if (r_state == IDLE && start) begin
      r_strided <= strided;
      r_vm      <= vm;
      r_sew     <= vsew == 3'b000 ? 2'd0 : vsew == 3'b001 ? 2'd1 : 2'd2;
      r_lmul    <= lmul == 3'b001 ? 2'd1 : lmul == 3'b010 ? 2'd2 : 2'd0;
      r_stride  <= stride;
      r_base    <= base_addr;
      r_data    <= data;
      r_mask    <= mask;
    end
  end
  // beat counter: zero while idle, advance on each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_beat <= '0;
    else if (r_state == IDLE)       r_beat <= '0;
    else if (w_st && mem_ready)     r_beat <= r_beat + 1'b1;
  end
  for (genvar k = 0; k < NBANKS; k++) begin : g_bank
    logic [EW-1:0]     w_e;
    logic [EW+4:0]     w_sh;
    logic [31:0]       w_d;
    logic              w_m;
    logic [ADDR_W-1:0] w_addr;
    assign w_e    = (EW'(r_beat) << NL) + EW'(k);
    assign w_sh   = (EW+5)'(w_e) << ({1'b0, r_sew} + 3'd3);
    assign w_d    = 32'(r_data >> w_sh);
    assign w_m    = 1'(r_mask >> w_e);
    assign w_addr = r_base + ADDR_W'(w_e) * (r_strided ? r_stride : ADDR_W'(1));
    assign bank_addr[k*ADDR_W +: ADDR_W]  = w_st ? w_addr : '0;
    assign bank_wdata[k*DATA_W +: DATA_W] = !w_st ? '0 :
                                            r_sew == 2'd0 ? DATA_W'($signed(w_d[7:0])) :
                                            r_sew == 2'd1 ? DATA_W'($signed(w_d[15:0])) :
                                                            DATA_W'($signed(w_d[31:0]));
    assign bank_we[k] = w_st && w_e < w_nelem && (r_vm || w_m);
  end
endmodule

// File: tb/tb_v_store_engine.sv
// tb_v_store_engine: scoreboard bench for the vector store engine
module tb_v_store_engine;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          strided = 1'b0;
  logic [2:0]    vsew = 3'd0;
  logic [2:0]    lmul = 3'd0;
  logic [13:0]   stride = '0;
  logic [13:0]   base_addr = '0;
  logic [511:0]  data = '0;
  logic          vm = 1'b1;
  logic [63:0]   mask = '0;
  logic          mem_ready = 1'b1;
  logic [55:0]   bank_addr;
  logic [127:0]  bank_wdata;
  logic [3:0]    bank_we;
  logic          busy, done;
  int            n_vec = 0;
  int            n_err = 0;

  typedef struct packed {
    logic [55:0]  a, am;
    logic [127:0] d, dm;
    logic [3:0]   w;
  } beat_t;
  beat_t q[$];

  v_store_engine dut (
    .clk(clk), .rst(rst), .start(start), .strided(strided), .vsew(vsew), .lmul(lmul),
    .stride(stride), .base_addr(base_addr), .data(data), .vm(vm), .mask(mask),
    .mem_ready(mem_ready), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_we(bank_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected beats built element by element from the request
  task automatic push_model(input logic s, input logic [2:0] vs, input logic [2:0] lm,
                            input logic [13:0] st, input logic [13:0] ba,
                            input logic [511:0] d, input logic v, input logic [63:0] m);
    int sew, nel, nb;
    beat_t x;
    logic [511:0] t;
    logic [31:0] w;
    sew = vs == 3'd0 ? 8 : vs == 3'd1 ? 16 : 32;
    nel = (128 / sew) * (lm == 3'd1 ? 2 : lm == 3'd2 ? 4 : 1);
    nb  = (nel + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      x = '0;
      for (int k = 0; k < 4; k++) begin
        int e = b*4 + k;
        if (e < nel) begin
          t = d >> (e*sew);
          w = sew == 8 ? {{24{t[7]}}, t[7:0]} : sew == 16 ? {{16{t[15]}}, t[15:0]} : t[31:0];
          x.a[k*14 +: 14]  = 14'(int'(ba) + e * (s ? int'(st) : 1));
          x.am[k*14 +: 14] = '1;
          x.d[k*32 +: 32]  = w;
          x.dm[k*32 +: 32] = '1;
          x.w[k]           = v | m[e];
        end
      end
      q.push_back(x);
    end
  endtask

  // monitor: compare every STORE cycle against the head, pop on acceptance
  initial begin
    beat_t x;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && busy && !done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_queue: unexpected beat addr %h, expected none", bank_addr);
        end else begin
          x = q[0];
          check("addr", {72'd0, bank_addr & x.am}, {72'd0, x.a});
          check("wdata", bank_wdata & x.dm, x.d);
          check("we", {124'd0, bank_we}, {124'd0, x.w});
          if (mem_ready) void'(q.pop_front());
        end
      end
    end
  end

  // caller is positioned at a negedge; start is sampled at the following posedge
  task automatic run_store(input int tid, input logic s, input logic [2:0] vs, input logic [2:0] lm,
                           input logic [13:0] st, input logic [13:0] ba, input logic [511:0] d,
                           input logic v, input logic [63:0] m, input int sa, input int sl,
                           input logic hold, input int exp_lat);
    int j = 0;
    logic got = 1'b0;
    strided = s; vsew = vs; lmul = lm; stride = st; base_addr = ba; data = d; vm = v; mask = m;
    start = 1'b1; mem_ready = 1'b1;
    push_model(s, vs, lm, st, ba, d, v, m);
    while (!got && j < 200) begin
      @(negedge clk);
      j++;
      if (!hold) start = 1'b0;
      if (j == 1) begin
        data = ~d; base_addr = ba + 14'd7; stride = st + 14'd1; vm = ~v; mask = ~m;
        vsew = ~vs; lmul = ~lm; strided = ~s;
      end
      mem_ready = !(j >= sa && j < sa + sl);
      if (tid == 1 && j == 1) begin
        check("a_addr", {72'd0, bank_addr}, {72'd0, 14'h103, 14'h102, 14'h101, 14'h100});
        check("a_we", {124'd0, bank_we}, 128'hF);
      end
      if (tid == 2 && j == 1)
        check("b_addr0", {72'd0, bank_addr}, {72'd0, 14'h19, 14'h16, 14'h13, 14'h10});
      if (tid == 2 && j == 16) begin
        check("b_addr15", {114'd0, bank_addr[55:42]}, 128'hCD);
        check("b_byte80", {96'd0, bank_wdata[127:96]}, 128'hFFFFFF80);
      end
      if (tid == 3 && j <= 4)
        check("c_we", {124'd0, bank_we}, 128'h5);
      if (tid == 5 && j == 1)
        check("e_wrap", {72'd0, bank_addr}, {72'd0, 14'h0001, 14'h0000, 14'h3FFF, 14'h3FFE});
      if (tid == 7 && j <= 4)
        check("g_stride0", {72'd0, bank_addr}, {72'd0, 14'h55, 14'h55, 14'h55, 14'h55});
      if (tid == 8 && j == 1)
        check("h_rsv", {72'd0, bank_addr}, {72'd0, 14'h3, 14'h2, 14'h1, 14'h0});
      if (done) got = 1'b1;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    check("latency", 128'(j), 128'(exp_lat));
    check("queue_empty", 128'(q.size()), 128'd0);
    @(negedge clk);
    check("done_pulse", {127'd0, done}, 128'd0);
    check("busy_idle", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    logic [511:0] d;
    #3;
    check("rst_addr", {72'd0, bank_addr}, 128'd0);
    check("rst_wdata", bank_wdata, 128'd0);
    check("rst_we_busy_done", {121'd0, bank_we, busy, done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_store(1, 1'b0, 3'b010, 3'b000, 14'd0, 14'h100,
              {384'h5555, 32'h8000_0003, 32'h7FFF_FFFF, 32'h0000_1234, 32'hDEAD_BEEF},
              1'b1, 64'd0, 0, 0, 1'b0, 2);
    for (int i = 0; i < 63; i++) d[i*8 +: 8] = 8'(i);
    d[511:504] = 8'h80;
    run_store(2, 1'b1, 3'b000, 3'b010, 14'd3, 14'h10, d, 1'b1, 64'd0, 0, 0, 1'b0, 17);
    d = '0;
    for (int i = 0; i < 32; i++) d[i*16 +: 16] = 16'(16'h8000 + i * 16'h0111);
    run_store(3, 1'b0, 3'b001, 3'b001, 14'd0, 14'h40, d, 1'b0, 64'hFFFF_FFFF_FFFF_5555,
              0, 0, 1'b0, 5);
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'hF00D_0000 + 32'(i);
    run_store(4, 1'b0, 3'b010, 3'b010, 14'd0, 14'h200, d, 1'b1, 64'd0, 2, 3, 1'b1, 8);
    run_store(5, 1'b0, 3'b010, 3'b000, 14'd5, 14'h3FFE, d, 1'b1, 64'd0, 0, 0, 1'b0, 2);
    strided = 1'b0; vsew = 3'b010; lmul = 3'b010; base_addr = 14'h300; data = d; vm = 1'b1;
    start = 1'b1;
    push_model(1'b0, 3'b010, 3'b010, 14'd0, 14'h300, d, 1'b1, 64'd0);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_we_busy_done", {121'd0, bank_we, busy, done}, 128'd0);
    check("abort_addr", {72'd0, bank_addr}, 128'd0);
    check("abort_wdata", bank_wdata, 128'd0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", {127'd0, done}, 128'd0);
    end
    rst = 1'b0;
    run_store(7, 1'b1, 3'b000, 3'b000, 14'd0, 14'h55, d, 1'b1, 64'd0, 0, 0, 1'b0, 5);
    run_store(8, 1'b0, 3'b011, 3'b111, 14'd0, 14'h0, d, 1'b1, 64'd0, 0, 0, 1'b0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
